// File: rtl/execute_writeback_unit.sv
// Execute stage feeding a 16x8 register file: single-cycle ALU with write-back forwarding,
// plus an 8-step shift-add multiplier for MUL/MULH.
module execute_writeback_unit #(
  parameter bit          ENABLE_FORWARD = 1'b1,
  parameter int unsigned MUL_STEPS      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       debug_inner,
  input  logic       issue_valid,
  output logic       issue_ready,
  input  logic [3:0] opcode,
  input  logic [3:0] rd,
  input  logic [3:0] rs,
  output logic [3:0] read_addr_A,
  output logic [3:0] read_addr_B,
  input  logic [7:0] read_data_A,
  input  logic [7:0] read_data_B,
  output logic [3:0] write_addr,
  output logic [7:0] write_data,
  output logic       write_enable,
  output logic       flag_z,
  output logic       flag_n,
  output logic       flag_c
);

  localparam logic [3:0] OpNop  = 4'h0;
  localparam logic [3:0] OpMov  = 4'h1;
  localparam logic [3:0] OpAdd  = 4'h2;
  localparam logic [3:0] OpSub  = 4'h3;
  localparam logic [3:0] OpAnd  = 4'h4;
  localparam logic [3:0] OpOr   = 4'h5;
  localparam logic [3:0] OpXor  = 4'h6;
  localparam logic [3:0] OpNot  = 4'h7;
  localparam logic [3:0] OpShl  = 4'h8;
  localparam logic [3:0] OpShr  = 4'h9;
  localparam logic [3:0] OpInc  = 4'hA;
  localparam logic [3:0] OpDec  = 4'hB;
  localparam logic [3:0] OpCmp  = 4'hC;
  localparam logic [3:0] OpMul  = 4'hD;
  localparam logic [3:0] OpMulh = 4'hE;

  localparam int unsigned StepW = $clog2(MUL_STEPS + 1);
  localparam logic [StepW-1:0] StepLast = StepW'(MUL_STEPS - 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e            state_q, state_d;
  logic [3:0]        wa_q, wa_d;
  logic [7:0]        wd_q, wd_d;
  logic              we_q, we_d;
  logic              z_q, z_d, n_q, n_d, c_q, c_d;
  logic [15:0]       mcand_q, mcand_d;
  logic [7:0]        mplier_q, mplier_d;
  logic [15:0]       prod_q, prod_d;
  logic [StepW-1:0]  step_q, step_d;
  logic              mul_high_q, mul_high_d;
  logic [3:0]        mul_rd_q, mul_rd_d;

  logic       accept;
  logic       is_mul;
  logic [7:0] op_a, op_b;
  logic [7:0] alu_res;
  logic       alu_wr, alu_fl, alu_c;
  logic [15:0] prod_sum;
  logic [7:0]  mul_byte;

  assign issue_ready  = (state_q == StIdle);
  assign accept       = issue_valid && issue_ready;
  assign read_addr_A  = rd;
  assign read_addr_B  = rs;
  assign write_addr   = wa_q;
  assign write_data   = wd_q;
  assign write_enable = we_q;
  assign flag_z       = z_q;
  assign flag_n       = n_q;
  assign flag_c       = c_q;

  // The pending write-back has not reached the register file yet, so bypass it.
  assign op_a = (ENABLE_FORWARD && we_q && (wa_q == rd)) ? wd_q : read_data_A;
  assign op_b = (ENABLE_FORWARD && we_q && (wa_q == rs)) ? wd_q : read_data_B;

  assign is_mul   = (opcode == OpMul) || (opcode == OpMulh);
  assign prod_sum = prod_q + (mplier_q[0] ? mcand_q : 16'h0000);
  assign mul_byte = mul_high_q ? prod_sum[15:8] : prod_sum[7:0];

  always_comb begin
    alu_res = 8'h00;
    alu_wr  = 1'b1;
    alu_fl  = 1'b1;
    alu_c   = 1'b0;
    case (opcode)
      OpMov: begin
        alu_res = op_b;
        alu_fl  = 1'b0;
      end
      OpAdd: {alu_c, alu_res} = {1'b0, op_a} + {1'b0, op_b};
      OpSub: {alu_c, alu_res} = {1'b0, op_a} - {1'b0, op_b};
      OpCmp: begin
        {alu_c, alu_res} = {1'b0, op_a} - {1'b0, op_b};
        alu_wr = 1'b0;
      end
      OpAnd: alu_res = op_a & op_b;
      OpOr:  alu_res = op_a | op_b;
      OpXor: alu_res = op_a ^ op_b;
      OpNot: alu_res = ~op_a;
      OpShl: begin
        alu_res = {op_a[6:0], 1'b0};
        alu_c   = op_a[7];
      end
      OpShr: begin
        alu_res = {1'b0, op_a[7:1]};
        alu_c   = op_a[0];
      end
      OpInc: begin
        alu_res = op_a + 8'd1;
        alu_c   = (op_a == 8'hFF);
      end
      OpDec: begin
        alu_res = op_a - 8'd1;
        alu_c   = (op_a == 8'h00);
      end
      default: begin
        // NOP, 0xF, and MUL/MULH (handled by the multiplier path)
        alu_wr = 1'b0;
        alu_fl = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wa_d       = wa_q;
    wd_d       = wd_q;
    we_d       = 1'b0;
    z_d        = z_q;
    n_d        = n_q;
    c_d        = c_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    prod_d     = prod_q;
    step_d     = step_q;
    mul_high_d = mul_high_q;
    mul_rd_d   = mul_rd_q;
    unique case (state_q)
      StIdle: begin
        if (accept && is_mul) begin
          mcand_d    = {8'h00, op_a};
          mplier_d   = op_b;
          prod_d     = 16'h0000;
          step_d     = '0;
          mul_high_d = (opcode == OpMulh);
          mul_rd_d   = rd;
          state_d    = StBusy;
        end else if (accept) begin
          if (alu_wr) begin
            wa_d = rd;
            wd_d = alu_res;
            we_d = 1'b1;
          end
          if (alu_fl) begin
            z_d = (alu_res == 8'h00);
            n_d = alu_res[7];
            c_d = alu_c;
          end
        end
      end
      StBusy: begin
        prod_d   = prod_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        step_d   = step_q + 1'b1;
        if (step_q == StepLast) begin
          wa_d    = mul_rd_q;
          wd_d    = mul_byte;
          we_d    = 1'b1;
          z_d     = (mul_byte == 8'h00);
          n_d     = mul_byte[7];
          c_d     = mul_high_q ? 1'b0 : (prod_sum[15:8] != 8'h00);
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      wa_q       <= 4'h0;
      wd_q       <= 8'h00;
      we_q       <= 1'b0;
      z_q        <= 1'b0;
      n_q        <= 1'b0;
      c_q        <= 1'b0;
      mcand_q    <= 16'h0000;
      mplier_q   <= 8'h00;
      prod_q     <= 16'h0000;
      step_q     <= '0;
      mul_high_q <= 1'b0;
      mul_rd_q   <= 4'h0;
    end else begin
      state_q    <= state_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      we_q       <= we_d;
      z_q        <= z_d;
      n_q        <= n_d;
      c_q        <= c_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      prod_q     <= prod_d;
      step_q     <= step_d;
      mul_high_q <= mul_high_d;
      mul_rd_q   <= mul_rd_d;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (debug_inner && reset) begin
      if (accept) $display("%0t issue op=%h rd=%h rs=%h", $time, opcode, rd, rs);
      if (we_q) $display("%0t wb addr=%h data=%h", $time, wa_q, wd_q);
    end
  end
`endif

endmodule

// File: tb/tb_execute_writeback_unit.sv
// Randomised and directed bench for execute_writeback_unit; two instances (forwarding on/off)
// each backed by a behavioural register file.
module tb_execute_writeback_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       debug_inner = 1'b0;
  logic       issue_valid = 1'b0;
  logic [3:0] opcode = 4'h0, rd = 4'h0, rs = 4'h0;

  logic       issue_ready, ready1;
  logic [3:0] ra_a, ra_b, ra_a1, ra_b1, wa, wa1;
  logic [7:0] wd, wd1;
  logic       we, we1, z, n, c, z1, n1, c1;

  logic [7:0] rf0 [16];
  logic [7:0] rf1 [16];
  logic       pl_en = 1'b0;
  logic [3:0] pl_addr = 4'h0;
  logic [7:0] pl_data = 8'h00;

  logic [7:0] m_regs [16];
  logic       m_z, m_n, m_c;
  int tests = 0;
  int fails = 0;

  execute_writeback_unit dut (
    .clk(clk), .reset(reset), .debug_inner(debug_inner),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .opcode(opcode), .rd(rd), .rs(rs),
    .read_addr_A(ra_a), .read_addr_B(ra_b),
    .read_data_A(rf0[ra_a]), .read_data_B(rf0[ra_b]),
    .write_addr(wa), .write_data(wd), .write_enable(we),
    .flag_z(z), .flag_n(n), .flag_c(c)
  );

  execute_writeback_unit #(.ENABLE_FORWARD(1'b0)) dut_nf (
    .clk(clk), .reset(reset), .debug_inner(debug_inner),
    .issue_valid(issue_valid), .issue_ready(ready1),
    .opcode(opcode), .rd(rd), .rs(rs),
    .read_addr_A(ra_a1), .read_addr_B(ra_b1),
    .read_data_A(rf1[ra_a1]), .read_data_B(rf1[ra_b1]),
    .write_addr(wa1), .write_data(wd1), .write_enable(we1),
    .flag_z(z1), .flag_n(n1), .flag_c(c1)
  );

  always #5 clk = ~clk;

  // Register file: a write lands on the edge after write_enable is seen.
  always @(posedge clk) begin
    if (we) rf0[wa] <= wd;
    if (we1) rf1[wa1] <= wd1;
    if (pl_en) begin
      rf0[pl_addr] <= pl_data;
      rf1[pl_addr] <= pl_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // Architectural reference: sequential ISA semantics on plain integers.
  function automatic void model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                output logic wr, output logic fl, output logic [7:0] r,
                                output logic ez, output logic en, output logic ec);
    int ai, bi, full;
    ai = a; bi = b; full = 0;
    wr = 1'b1; fl = 1'b1; ec = 1'b0;
    case (op)
      4'h1: begin full = bi; fl = 1'b0; end
      4'h2: begin full = ai + bi; ec = (full > 255); end
      4'h3: begin full = ai - bi; ec = (ai < bi); end
      4'h4: full = ai & bi;
      4'h5: full = ai | bi;
      4'h6: full = ai ^ bi;
      4'h7: full = 255 - ai;
      4'h8: begin full = ai * 2; ec = (ai >= 128); end
      4'h9: begin full = ai / 2; ec = (ai % 2) == 1; end
      4'hA: begin full = ai + 1; ec = (ai == 255); end
      4'hB: begin full = ai - 1; ec = (ai == 0); end
      4'hC: begin full = ai - bi; ec = (ai < bi); wr = 1'b0; end
      4'hD: begin full = ai * bi; ec = ((ai * bi) / 256) != 0; end
      4'hE: full = (ai * bi) / 256;
      default: begin wr = 1'b0; fl = 1'b0; end
    endcase
    r  = 8'(full & 255);
    ez = (r == 8'h00);
    en = (r >= 8'h80);
  endfunction

  task automatic preload(input logic [3:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
    m_regs[a] = d;
  endtask

  task automatic drive(input logic [3:0] op, input logic [3:0] d, input logic [3:0] s);
    issue_valid = 1'b1; opcode = op; rd = d; rs = s;
  endtask

  // Waits for the next write-back; counts edges and busy samples, bounded.
  task automatic wait_wb(output int cyc, output int low);
    cyc = 0; low = 0;
    while (!we && cyc < 20) begin
      if (!issue_ready) low++;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    int saw;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (we !== 1'b0) begin fails++; $display("FAIL rst_we got %b want 0", we); end
    tests++; if (wa !== 4'h0) begin fails++; $display("FAIL rst_addr got %h want 0", wa); end
    tests++; if (wd !== 8'h00) begin fails++; $display("FAIL rst_data got %h want 00", wd); end
    tests++; if ({z, n, c} !== 3'b000) begin
      fails++; $display("FAIL rst_flags got %b want 000", {z, n, c});
    end
    tests++; if (issue_ready !== 1'b1) begin
      fails++; $display("FAIL rst_ready got %b want 1", issue_ready);
    end
    reset = 1'b1;
    preload(4'h6, 8'hF0);
    preload(4'h7, 8'h20);
    drive(4'h2, 4'h6, 4'h7);
    @(posedge clk); #1;
    drive(4'hD, 4'h6, 4'h7);
    @(posedge clk); #1;
    issue_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (issue_ready !== 1'b0) begin
      fails++; $display("FAIL rst_busy got ready=%b want 0", issue_ready);
    end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if ({we, wd} !== 9'h000) begin
      fails++; $display("FAIL rst_mid_wb got we=%b data=%h want 0/00", we, wd);
    end
    tests++; if ({z, n, c} !== 3'b000) begin
      fails++; $display("FAIL rst_mid_flags got %b want 000", {z, n, c});
    end
    tests++; if (issue_ready !== 1'b1) begin
      fails++; $display("FAIL rst_mid_ready got %b want 1", issue_ready);
    end
    reset = 1'b1;
    saw = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (we) saw++;
    end
    tests++; if (saw != 0) begin fails++; $display("FAIL rst_no_wb got %0d pulses want 0", saw); end
  endtask

  task automatic test_random();
    logic [7:0] a, b, r;
    logic wr, fl, ez, en, ec;
    logic [3:0] op, d, s;
    int cyc, low;
    for (int i = 0; i < 16; i++) preload(4'(i), 8'($urandom_range(0, 255)));
    m_z = 1'b0; m_n = 1'b0; m_c = 1'b0;
    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom_range(0, 15));
      d  = 4'($urandom_range(0, 15));
      s  = 4'($urandom_range(0, 15));
      a  = m_regs[d];
      b  = m_regs[s];
      model(op, a, b, wr, fl, r, ez, en, ec);
      if (fl) begin m_z = ez; m_n = en; m_c = ec; end
      drive(op, d, s);
      @(posedge clk); #1;
      if (op == 4'hD || op == 4'hE) begin
        issue_valid = 1'b0;
        tests++; if (we !== 1'b0) begin fails++; $display("FAIL rnd_mul_accept we=%b want 0", we); end
        wait_wb(cyc, low);
        tests++; if (cyc != 8) begin
          fails++; $display("FAIL rnd_mul_latency got %0d want 8", cyc);
        end
      end
      tests++; if (we !== wr) begin
        fails++; $display("FAIL rnd_we op=%h got %b want %b", op, we, wr);
      end
      if (wr) begin
        tests++; if ({wa, wd} !== {d, r}) begin
          fails++; $display("FAIL rnd_wb op=%h got %h/%h want %h/%h", op, wa, wd, d, r);
        end
        m_regs[d] = r;
      end
      tests++; if ({z, n, c} !== {m_z, m_n, m_c}) begin
        fails++; $display("FAIL rnd_flags op=%h got %b want %b", op, {z, n, c}, {m_z, m_n, m_c});
      end
    end
    issue_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add_sub();
    preload(4'h1, 8'hF0);
    preload(4'h2, 8'h20);
    preload(4'h3, 8'h05);
    drive(4'h2, 4'h1, 4'h2);
    @(posedge clk); #1;
    tests++; if ({we, wa, wd} !== {1'b1, 4'h1, 8'h10}) begin
      fails++; $display("FAIL add_wb got %b/%h/%h want 1/1/10", we, wa, wd);
    end
    tests++; if ({z, n, c} !== 3'b001) begin
      fails++; $display("FAIL add_flags got %b want 001", {z, n, c});
    end
    drive(4'h3, 4'h3, 4'h3);
    @(posedge clk); #1;
    issue_valid = 1'b0;
    tests++; if ({we, wa, wd} !== {1'b1, 4'h3, 8'h00}) begin
      fails++; $display("FAIL sub_wb got %b/%h/%h want 1/3/00", we, wa, wd);
    end
    tests++; if ({z, n, c} !== 3'b100) begin
      fails++; $display("FAIL sub_flags got %b want 100", {z, n, c});
    end
  endtask

  task automatic test_forward();
    preload(4'h4, 8'h00);
    preload(4'h5, 8'h7F);
    drive(4'h1, 4'h4, 4'h5);
    @(posedge clk); #1;
    drive(4'hA, 4'h4, 4'h4);
    @(posedge clk); #1;
    issue_valid = 1'b0;
    tests++; if (wd !== 8'h80) begin fails++; $display("FAIL fwd_data got %h want 80", wd); end
    tests++; if ({n, c} !== 2'b10) begin fails++; $display("FAIL fwd_nc got %b want 10", {n, c}); end
    tests++; if ({we1, wd1} !== {1'b1, 8'h01}) begin
      fails++; $display("FAIL nofwd_data got %b/%h want 1/01", we1, wd1);
    end
    tests++; if ({ready1, z1, n1, c1} !== 4'b1000) begin
      fails++; $display("FAIL nofwd_flags got %b want 1000", {ready1, z1, n1, c1});
    end
  endtask

  task automatic test_mul();
    int cyc, low;
    preload(4'h6, 8'h0F);
    preload(4'h7, 8'h11);
    preload(4'h8, 8'hFF);
    preload(4'h9, 8'hFF);
    preload(4'hA, 8'hFF);
    drive(4'hD, 4'h6, 4'h7);
    @(posedge clk); #1;
    issue_valid = 1'b0;
    wait_wb(cyc, low);
    tests++; if (low != 8) begin fails++; $display("FAIL mul_busy got %0d want 8", low); end
    tests++; if ({we, wa, wd} !== {1'b1, 4'h6, 8'hFF}) begin
      fails++; $display("FAIL mul_wb got %b/%h/%h want 1/6/ff", we, wa, wd);
    end
    tests++; if ({z, n, c, issue_ready} !== 4'b0101) begin
      fails++; $display("FAIL mul_flags got %b want 0101", {z, n, c, issue_ready});
    end
    drive(4'hE, 4'h8, 4'h9);
    @(posedge clk); #1;
    issue_valid = 1'b0;
    wait_wb(cyc, low);
    tests++; if ({wd, c} !== {8'hFE, 1'b0}) begin
      fails++; $display("FAIL mulh_ff got %h/%b want fe/0", wd, c);
    end
    drive(4'hD, 4'h9, 4'hA);
    @(posedge clk); #1;
    issue_valid = 1'b0;
    wait_wb(cyc, low);
    tests++; if ({wd, c} !== {8'h01, 1'b1}) begin
      fails++; $display("FAIL mul_ff got %h/%b want 01/1", wd, c);
    end
  endtask

  task automatic test_cmp_nop();
    logic [3:0] ops [3];
    ops[0] = 4'hC; ops[1] = 4'h0; ops[2] = 4'hF;
    preload(4'h1, 8'h10);
    preload(4'h2, 8'h20);
    for (int i = 0; i < 3; i++) begin
      drive(ops[i], 4'h1, 4'h2);
      @(posedge clk); #1;
      tests++; if (we !== 1'b0) begin fails++; $display("FAIL cmp_nop_we op=%h got 1", ops[i]); end
      tests++; if ({z, n, c} !== 3'b011) begin
        fails++; $display("FAIL cmp_nop_flags op=%h got %b want 011", ops[i], {z, n, c});
      end
    end
    issue_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [11:0] seen [$];
    int at [$];
    logic rdy;
    preload(4'h6, 8'h03);
    preload(4'h7, 8'h05);
    preload(4'h1, 8'h10);
    preload(4'h2, 8'h20);
    drive(4'hD, 4'h6, 4'h7);
    @(posedge clk); #1;
    drive(4'h2, 4'h1, 4'h2);
    for (int i = 0; i < 16; i++) begin
      rdy = issue_ready;
      @(posedge clk); #1;
      if (issue_valid && rdy) issue_valid = 1'b0;
      if (we) begin seen.push_back({wa, wd}); at.push_back(i); end
    end
    issue_valid = 1'b0;
    tests++; if (seen.size() != 2) begin
      fails++; $display("FAIL b2b_count got %0d want 2", seen.size());
    end
    if (seen.size() == 2) begin
      tests++; if (seen[0] !== 12'h60F) begin
        fails++; $display("FAIL b2b_first got %h want 60f", seen[0]);
      end
      tests++; if (seen[1] !== 12'h130) begin
        fails++; $display("FAIL b2b_second got %h want 130", seen[1]);
      end
      tests++; if (at[0] != 7 || at[1] != 8) begin
        fails++; $display("FAIL b2b_timing got %0d,%0d want 7,8", at[0], at[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_random();
    test_add_sub();
    test_forward();
    test_mul();
    test_cmp_nop();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/execute_writeback_unit.md
Name: execute_writeback_unit

Overview:
- Execute stage sitting directly upstream of the 16x8 register file.
- Accepts one decoded instruction per handshake and drives the file's read addresses.
- Computes the ALU result with operand forwarding from its own pending write-back, and updates Z/N/C flags.
- Produces the file's write port signals (write_addr, write_data, write_enable); MUL/MULH run as an 8-step multi-cycle shift-add.

Parameters:
- ENABLE_FORWARD, 1, 1 = bypass pending wb_data onto operands when the read address matches wb_addr; 0 = raw register-file data.
- MUL_STEPS, 8, shift-add iterations for MUL/MULH; fixed at the data width, must equal 8.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- debug_inner  in  1  enables $display trace of issue and write-back (simulation only)
- issue_valid  in  1  instruction present on opcode/rd/rs
- issue_ready  out  1  stage can accept; combinational, high iff state==IDLE
- opcode  in  4  operation select (table below)
- rd  in  4  destination register, also operand A
- rs  in  4  operand B register
- read_addr_A  out  4  to register file; combinational = rd
- read_addr_B  out  4  to register file; combinational = rs
- read_data_A  in  8  from register file
- read_data_B  in  8  from register file
- write_addr  out  4  registered write-back address
- write_data  out  8  registered write-back data
- write_enable  out  1  registered, one-cycle pulse per write-back
- flag_z  out  1  zero flag
- flag_n  out  1  negative flag (result[7])
- flag_c  out  1  carry/borrow flag

Behaviour:
- Reset (reset==0 at posedge): state IDLE, write_enable 0, write_addr 0, write_data 0, flags 0, multiplier regs and step counter 0. Reset during BUSY abandons the multiply; no write-back occurs.
- Accept: a posedge with issue_valid && issue_ready. Operands A and B are sampled at that edge.
- Forwarding (ENABLE_FORWARD=1): if write_enable && write_addr==rd, A = write_data; likewise B for rs. Both may forward. Otherwise the read_data inputs are used.
- Opcodes (R = result):
  - 0 NOP: no write, flags unchanged.
  - 1 MOV: R=B; flags unchanged.
  - 2 ADD: C = carry out of A+B.
  - 3 SUB: R=A-B; C = borrow (A<B).
  - 4 AND, 5 OR, 6 XOR: C=0.
  - 7 NOT: R=~A; C=0.
  - 8 SHL: R=A<<1; C=A[7].
  - 9 SHR: R=A>>1 (logical); C=A[0].
  - A INC: C = (A==FF).
  - B DEC: C = (A==00).
  - C CMP: as SUB, flags only, no write.
  - D MUL: R = low byte of A*B.
  - E MULH: R = high byte of A*B.
  - F: treated as NOP.
- Z = (R==0) and N = R[7] for every flag-updating op. Arithmetic is modulo 256.
- Single-cycle ops: on the accepting edge, write_addr<=rd, write_data<=R, write_enable<=1, and flags update. Write-back appears in the cycle after accept. State stays IDLE, so back-to-back issue is allowed every cycle.
- Non-writing ops (NOP, CMP, F): write_enable<=0 on the accepting edge.
- Any edge with no accept in IDLE: write_enable<=0; write_addr/write_data hold.
- MUL/MULH state machine, IDLE -> BUSY -> IDLE:
  - Accept edge: load multiplicand A (zero-extended to 16 bits), multiplier B, product 0, step 0; write_enable<=0; go to BUSY.
  - Each BUSY edge: if multiplier[0], product += multiplicand; then multiplicand<<=1, multiplier>>=1, step++.
  - On the 8th BUSY edge (accept edge + 8): load write_data with the low or high byte of the final product and set write_enable<=1.
  - That edge also sets flags: Z and N from the written byte; C = (high byte != 0) for MUL, C=0 for MULH.
  - Return to IDLE on that edge, so issue_ready is high in the write-back cycle.
- issue_valid during BUSY is ignored (not accepted). The issuer holds it until issue_ready.
- Register-file write lands one edge after write_enable rises. Forwarding covers the read of that register in the write-back cycle.
- debug_inner=1: print opcode/rd/rs at accept and addr/data at each write-back, with $time.

Test Plan:
- Reset: hold reset=0 for 2 cycles mid-MUL -> write_enable, flags and write_data all 0, issue_ready=1, no write-back afterwards.
- ADD r1(0xF0)+r2(0x20) -> next cycle write_enable=1, write_addr=1, write_data=0x10, C=1, Z=0, N=0. Then SUB r3(0x05)-r3 -> write_data 0x00, Z=1, C=0.
- Back-to-back forwarding: MOV r4<-r5(0x7F), then next cycle INC r4 (regfile still holds old r4=0x00) -> write_data=0x80, N=1, C=0. Repeat with ENABLE_FORWARD=0 -> write_data=0x01.
- MUL r6(0x0F)*r7(0x11): issue_ready low for exactly 8 cycles after accept; write_data=0xFF, C=0. MULH 0xFF*0xFF -> write_data=0xFE, C=0; MUL 0xFF*0xFF -> 0x01, C=1.
- CMP r1(0x10) vs r2(0x20) -> no write_enable, C=1, N=1, Z=0. Then NOP and opcode F -> flags unchanged, no write.
- issue_valid held high through BUSY with a second ADD queued -> ADD accepted only on the write-back cycle of the MUL, producing exactly two write_enable pulses, in order.
